// File: rtl/instr_fetch_unit.sv
// Purpose  : owns the PC, reads 1- or 2-byte instructions from byte memory and
//            hands each one to the control unit with a valid/ready handshake.
// Latency  : 1-byte instr valid 1 granted cycle after fetch start, 2-byte after 2.
// Backpressure: instr held stable in HOLD while instr_ready=0; fetch stalls while
//            mem_grant=0; jump_en overrides everything and drops any pending instr.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   mem_grant                1 = fetch owns the memory port this cycle
//   mem_address, mem_read    byte address (always the PC) and read strobe
//   mem_data                 combinational read data for mem_address
//   jump_en, jump_addr       one-cycle PC redirect
//   instr, instr_len2,
//   instr_pc, instr_valid    instruction hand-off to the control unit
//   instr_ready              control unit accepts instr this cycle
module instr_fetch_unit #(
   parameter int                 ADDR_W   = 13,
   parameter int                 DATA_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_grant,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_read,
   input  logic [DATA_W-1:0]     mem_data,
   input  logic                  jump_en,
   input  logic [ADDR_W-1:0]     jump_addr,
   output logic [2*DATA_W-1:0]   instr,
   output logic                  instr_len2,
   output logic [ADDR_W-1:0]     instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready
);

   typedef enum logic [1:0] {
      FETCH0 = 2'd0,
      FETCH1 = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]     byte0_q, byte0_d;
   logic [2*DATA_W-1:0]   instr_q, instr_d;
   logic                  instr_len2_q, instr_len2_d;
   logic [ADDR_W-1:0]     instr_pc_q, instr_pc_d;
   logic                  instr_valid_q, instr_valid_d;

   logic                  fetching;
   logic                  is_short;

   assign fetching = (state_q == FETCH0) || (state_q == FETCH1);
   // Opcodes 111xxxxx carry no operand byte.
   assign is_short = (mem_data[DATA_W-1 -: 3] == 3'b111);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      byte0_d       = byte0_q;
      instr_d       = instr_q;
      instr_len2_d  = instr_len2_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;

      if (jump_en) begin
         // Redirect wins: partial byte0 is abandoned and a held instr is dropped
         // even if the control unit is accepting it in this same cycle.
         pc_d          = jump_addr;
         instr_valid_d = 1'b0;
         state_d       = FETCH0;
      end else begin
         case (state_q)
            FETCH0: begin
               if (mem_grant) begin
                  byte0_d    = mem_data;
                  instr_pc_d = pc_q;
                  pc_d       = pc_q + ADDR_W'(1);
                  if (is_short) begin
                     instr_d       = {mem_data, {DATA_W{1'b0}}};
                     instr_len2_d  = 1'b0;
                     instr_valid_d = 1'b1;
                     state_d       = HOLD;
                  end else begin
                     state_d = FETCH1;
                  end
               end
            end
            FETCH1: begin
               if (mem_grant) begin
                  instr_d       = {byte0_q, mem_data};
                  instr_len2_d  = 1'b1;
                  pc_d          = pc_q + ADDR_W'(1);
                  instr_valid_d = 1'b1;
                  state_d       = HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid_d = 1'b0;
                  state_d       = FETCH0;
               end
            end
            default: begin
               state_d = FETCH0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= FETCH0;
         pc_q          <= RESET_PC;
         byte0_q       <= '0;
         instr_q       <= '0;
         instr_len2_q  <= 1'b0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         byte0_q       <= byte0_d;
         instr_q       <= instr_d;
         instr_len2_q  <= instr_len2_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // No speculative reads: strobe only in a fetch state with the port granted.
   assign mem_read    = fetching && mem_grant && rst;
   assign mem_address = pc_q;
   assign instr       = instr_q;
   assign instr_len2  = instr_len2_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_grant;
   logic [12:0] mem_address;
   logic        mem_read;
   logic [7:0]  mem_data;
   logic        jump_en;
   logic [12:0] jump_addr;
   logic [15:0] instr;
   logic        instr_len2;
   logic [12:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   logic [7:0]  mem [0:8191];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mem_data = mem[mem_address];

   instr_fetch_unit #(.ADDR_W(13), .DATA_W(8), .RESET_PC(13'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_grant   (mem_grant),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_data    (mem_data),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .instr       (instr),
      .instr_len2  (instr_len2),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   // Reference: the instruction found at address a, as {len2, byte0, byte1}.
   function automatic logic [16:0] ref_fetch(input logic [12:0] a);
      logic [7:0]  b0;
      logic [12:0] a1;
      b0 = mem[a];
      a1 = a + 13'd1;
      if (b0[7:5] == 3'b111) return {1'b0, b0, 8'h00};
      return {1'b1, b0, mem[a1]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_grant = 1'b1; instr_ready = 1'b1; jump_en = 1'b0; jump_addr = '0;
      #12;
      checks++;
      if (instr !== 16'h0 || instr_len2 !== 1'b0 || instr_pc !== 13'h0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got instr=%h len2=%b pc=%h valid=%b, want 0", instr, instr_len2, instr_pc, instr_valid);
      end
      checks++;
      if (mem_read !== 1'b0 || mem_address !== 13'h0) begin
         errors++;
         $display("FAIL reset_mem got read=%b addr=%h, want 0/0", mem_read, mem_address);
      end
   endtask

   task automatic test_basic();
      @(negedge clk); rst = 1'b1;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || mem_address !== 13'h1) begin
         errors++; $display("FAIL basic_fetch1 got valid=%b addr=%h, want 0/0001", instr_valid, mem_address);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h2510 || instr_len2 !== 1'b1 || instr_pc !== 13'h0 || mem_address !== 13'h2) begin
         errors++;
         $display("FAIL basic_2byte got v=%b i=%h l=%b pc=%h a=%h, want 1/2510/1/0000/0002", instr_valid, instr, instr_len2, instr_pc, mem_address);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0 || mem_address !== 13'h2) begin
         errors++; $display("FAIL basic_accept got valid=%b addr=%h, want 0/0002", instr_valid, mem_address);
      end
      instr_ready = 1'b0;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'hE300 || instr_len2 !== 1'b0 || instr_pc !== 13'h2 || mem_address !== 13'h3) begin
         errors++;
         $display("FAIL basic_1byte got v=%b i=%h l=%b pc=%h a=%h, want 1/e300/0/0002/0003", instr_valid, instr, instr_len2, instr_pc, mem_address);
      end
   endtask

   task automatic test_hold_backpressure();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (instr_valid !== 1'b1 || instr !== 16'hE300 || instr_pc !== 13'h2 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable cyc%0d got v=%b i=%h pc=%h rd=%b, want 1/e300/0002/0", i, instr_valid, instr, instr_pc, mem_read);
         end
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || mem_address !== 13'h3) begin
         errors++; $display("FAIL hold_accept got valid=%b addr=%h, want 0/0003", instr_valid, mem_address);
      end
   endtask

   task automatic test_grant_stall();
      tick();
      checks++;
      if (instr_valid !== 1'b0 || mem_address !== 13'h4 || mem_read !== 1'b1) begin
         errors++; $display("FAIL stall_fetch1 got v=%b a=%h rd=%b, want 0/0004/1", instr_valid, mem_address, mem_read);
      end
      mem_grant = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem_read !== 1'b0 || mem_address !== 13'h4 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL stall_frozen cyc%0d got rd=%b a=%h v=%b, want 0/0004/0", i, mem_read, mem_address, instr_valid);
         end
         tick();
      end
      mem_grant = 1'b1;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h5AC3 || instr_len2 !== 1'b1 || instr_pc !== 13'h3 || mem_address !== 13'h5) begin
         errors++;
         $display("FAIL stall_resume got v=%b i=%h l=%b pc=%h a=%h, want 1/5ac3/1/0003/0005", instr_valid, instr, instr_len2, instr_pc, mem_address);
      end
   endtask

   task automatic test_jump();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      checks++;
      if (mem_address !== 13'h6 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL jump_setup got a=%h v=%b, want 0006/0", mem_address, instr_valid);
      end
      jump_en = 1'b1; jump_addr = 13'h1ABC;
      tick();
      jump_en = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || mem_address !== 13'h1ABC) begin
         errors++; $display("FAIL jump_fetch1 got v=%b a=%h, want 0/1abc", instr_valid, mem_address);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'hE700 || instr_pc !== 13'h1ABC) begin
         errors++; $display("FAIL jump_target got v=%b i=%h pc=%h, want 1/e700/1abc", instr_valid, instr, instr_pc);
      end
      jump_en = 1'b1; instr_ready = 1'b1;
      tick();
      jump_en = 1'b0; instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || mem_address !== 13'h1ABC) begin
         errors++; $display("FAIL jump_hold got v=%b a=%h, want 0/1abc", instr_valid, mem_address);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 13'h1ABC || mem_address !== 13'h1ABD) begin
         errors++; $display("FAIL jump_refetch got v=%b pc=%h a=%h, want 1/1abc/1abd", instr_valid, instr_pc, mem_address);
      end
   endtask

   task automatic test_wrap_and_async_reset();
      jump_en = 1'b1; jump_addr = 13'h1FFF;
      tick();
      jump_en = 1'b0;
      tick();
      checks++;
      if (mem_address !== 13'h0 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_pc got a=%h v=%b, want 0000/0", mem_address, instr_valid);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h4007 || instr_pc !== 13'h1FFF || mem_address !== 13'h1) begin
         errors++; $display("FAIL wrap_instr got v=%b i=%h pc=%h a=%h, want 1/4007/1fff/0001", instr_valid, instr, instr_pc, mem_address);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      #3 rst = 1'b0;
      #1;
      checks++;
      if (instr !== 16'h0 || instr_len2 !== 1'b0 || instr_pc !== 13'h0 || instr_valid !== 1'b0 ||
          mem_read !== 1'b0 || mem_address !== 13'h0) begin
         errors++;
         $display("FAIL async_reset got i=%h l=%b pc=%h v=%b rd=%b a=%h, want all 0", instr, instr_len2, instr_pc, instr_valid, mem_read, mem_address);
      end
   endtask

   task automatic test_random();
      logic [12:0] exp_pc;
      logic [16:0] r;
      int accepted = 0;
      int jumps = 0;
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      exp_pc = 13'h0;
      mem_grant = 1'b0; instr_ready = 1'b0; jump_en = 1'b0;
      @(negedge clk); rst = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         mem_grant   = ($urandom_range(0, 9) < 7);
         instr_ready = ($urandom_range(0, 9) < 6);
         jump_en     = ($urandom_range(0, 99) < 3);
         jump_addr   = 13'($urandom_range(0, 8191));
         #1;
         checks++;
         if (mem_read !== (mem_grant && !instr_valid)) begin
            errors++; $display("FAIL rnd_mem_read cyc%0d got %b want %b", c, mem_read, mem_grant && !instr_valid);
         end
         if (jump_en) begin
            exp_pc = jump_addr;
            jumps++;
         end else if (instr_valid && instr_ready) begin
            r = ref_fetch(exp_pc);
            checks++;
            if (instr !== r[15:0] || instr_len2 !== r[16] || instr_pc !== exp_pc) begin
               errors++;
               $display("FAIL rnd_instr cyc%0d got i=%h l=%b pc=%h want i=%h l=%b pc=%h", c, instr, instr_len2, instr_pc, r[15:0], r[16], exp_pc);
            end
            exp_pc = exp_pc + (r[16] ? 13'd2 : 13'd1);
            accepted++;
         end
      end
      jump_en = 1'b0;
      checks++;
      if (accepted < 200) begin
         errors++; $display("FAIL rnd_progress got %0d accepted want >= 200", accepted);
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      mem[0]       = 8'h25;
      mem[1]       = 8'h10;
      mem[2]       = 8'hE3;
      mem[3]       = 8'h5A;
      mem[4]       = 8'hC3;
      mem[5]       = 8'h11;
      mem[13'h1ABC] = 8'hE7;
      mem[13'h1FFF] = 8'h40;
      test_reset();
      test_basic();
      test_hold_backpressure();
      test_grant_stall();
      test_jump();
      mem[0] = 8'h07;
      test_wrap_and_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
